// File: rtl/vga_bcd_snapshot_if.sv
// ---------------------------------------------------------------------------
// vga_bcd_snapshot_if
//   Bus bundle for vga_bcd_snapshot. It carries two ports:
//   - source port:   src_sel selects an RTC/timer channel, and src_data
//                    returns that channel's packed BCD byte one cycle later.
//   - renderer port: rd_ch/rd_digit select a shadow digit, and rd_ascii
//                    returns it one cycle later.
//   slave  : the snapshot block (drives src_sel, rd_ascii)
//   master : the surroundings (register bank + text renderer)
// ---------------------------------------------------------------------------
interface vga_bcd_snapshot_if #(
  parameter int CH_W = 4
);
  logic [CH_W-1:0] src_sel;
  logic [7:0]      src_data;
  logic [CH_W-1:0] rd_ch;
  logic            rd_digit;
  logic [6:0]      rd_ascii;

  modport slave (
    output src_sel,
    input  src_data,
    input  rd_ch,
    input  rd_digit,
    output rd_ascii
  );

  modport master (
    input  src_sel,
    output src_data,
    output rd_ch,
    output rd_digit,
    input  rd_ascii
  );
endinterface

// File: rtl/vga_bcd_snapshot.sv
// ---------------------------------------------------------------------------
// vga_bcd_snapshot
//   Once per frame, at the start of vertical blanking, this block copies
//   NUM_CH packed-BCD bytes from the RTC/timer bank into a shadow bank of
//   ASCII digits. The text renderer reads the shadow bank with 1-cycle
//   latency. The block also generates the cursor blink and alarm-band flash
//   phase, which toggles every BLINK_FRAMES frames.
//
// Ports
//   clk, reset    clock; asynchronous active-low reset
//   pixely        current line from the sync generator
//   bus           vga_bcd_snapshot_if.slave
//                   src_sel/src_data   channel walk of the RTC bank
//                   rd_ch/rd_digit     renderer select (digit 0 = units)
//                   rd_ascii           registered ASCII of the selection
//   cursor        channel under edit; a value >= NUM_CH means no cursor
//   ring          alarm active
//   cursor_hide   registered with rd_ascii; high when the cursor digit is
//                 being read during the blink-off phase
//   alarm_band    combinational: ring & flash-on & pixely in the band
//   snap_busy     capture in progress
//   snap_done     one-cycle pulse when a capture completes
//   bcd_err       (BCD_CHECK_EN only) sticky invalid-nibble flag
//
// Build option
//   BCD_CHECK_EN  When defined, nibbles > 9 are stored as '-' and the
//                 bcd_err output is added. When undefined, nibbles are
//                 stored raw ({3'b011, nibble}).
// ---------------------------------------------------------------------------
module vga_bcd_snapshot #(
  parameter int NUM_CH       = 11,
  parameter int CH_W         = 4,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30,
  parameter int BAND_TOP     = 473
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       pixely,
  vga_bcd_snapshot_if.slave bus,
  input  logic [CH_W-1:0]  cursor,
  input  logic             ring,
  output logic             cursor_hide,
  output logic             alarm_band,
  output logic             snap_busy,
  output logic             snap_done
`ifdef BCD_CHECK_EN
  ,
  output logic             bcd_err
`endif
);

  // One spare bit so the walk counter can reach NUM_CH even when
  // NUM_CH == 2**CH_W.
  localparam int               CNT_W = CH_W + 1;
  localparam int               FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_CH);
  localparam logic [6:0]       ASC_0 = 7'h30;
  localparam logic [6:0]       ASC_SP = 7'h20;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  function automatic logic [6:0] enc(input logic [3:0] n);
`ifdef BCD_CHECK_EN
    enc = (n > 4'd9) ? 7'h2D : {3'b011, n};
`else
    enc = {3'b011, n};
`endif
  endfunction

  // -------------------------------------------------------------------------
  // vblank_start: registered rising edge of (pixely >= V_ACTIVE).
  // The level flop resets to 1. A reset released in the middle of blanking
  // therefore waits for the next real blanking edge instead of capturing
  // immediately.
  // -------------------------------------------------------------------------
  logic in_vb;
  logic vb_lvl_q, vb_lvl_d;
  logic vbs_q, vbs_d;

  assign in_vb = (pixely >= 10'(V_ACTIVE));

  always_comb begin
    vb_lvl_d = in_vb;
    vbs_d    = in_vb & ~vb_lvl_q;
  end

  // -------------------------------------------------------------------------
  // Capture FSM. FETCH lasts NUM_CH+1 cycles. Cycles 0..NUM_CH-1 present
  // the channel index. Each cycle writes back the data for the index
  // presented in the previous cycle.
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             walk;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (vbs_q) state_d = FETCH;
      end
      FETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        // vblank_start arriving here is dropped; there is no re-arm.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign walk        = (state_q == FETCH) && (cnt_q < LAST);
  assign bus.src_sel = walk ? cnt_q[CH_W-1:0] : '0;
  assign snap_busy   = (state_q == FETCH);
  assign snap_done   = (state_q == DONE);

  // Write-back stage: src_data belongs to the index presented one cycle ago.
  logic            wr_vld_q, wr_vld_d;
  logic [CH_W-1:0] wr_sel_q, wr_sel_d;

  always_comb begin
    wr_vld_d = walk;
    wr_sel_d = bus.src_sel;
  end

  // -------------------------------------------------------------------------
  // Shadow bank: [channel][digit] holds ASCII. Digit 0 is units, digit 1 is tens.
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0][1:0][6:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_vld_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_sel_q == CH_W'(c)) begin
          shadow_d[c][0] = enc(bus.src_data[3:0]);
          shadow_d[c][1] = enc(bus.src_data[7:4]);
        end
      end
    end
  end

  // Read path. Channels past NUM_CH read as a blank.
  logic [6:0] rd_ascii_q, rd_ascii_d;

  always_comb begin
    rd_ascii_d = ASC_SP;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_ch == CH_W'(c)) rd_ascii_d = shadow_q[c][bus.rd_digit];
    end
  end

  assign bus.rd_ascii = rd_ascii_q;

  // -------------------------------------------------------------------------
  // Blink / flash phase. Phase 0 means the cursor is shown and the flash
  // is off. Phase 1 means the cursor is hidden and the flash is on.
  // -------------------------------------------------------------------------
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             ph_q, ph_d;
  logic             hide_q, hide_d;

  always_comb begin
    frm_d = frm_q;
    ph_d  = ph_q;
    if (vbs_q) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d = '0;
        ph_d  = ~ph_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // The compare is widened by one bit so that a cursor value of NUM_CH or
  // more never matches, even when NUM_CH == 2**CH_W.
  always_comb begin
    hide_d = (bus.rd_ch == cursor) && ({1'b0, cursor} < LAST) && ph_q;
  end

  assign cursor_hide = hide_q;
  assign alarm_band  = ring & ph_q & (pixely >= 10'(BAND_TOP)) & ~in_vb;

  // -------------------------------------------------------------------------
  // Optional BCD validity tracking
  // -------------------------------------------------------------------------
`ifdef BCD_CHECK_EN
  logic bad_wr;
  logic cap_bad_q, cap_bad_d;
  logic err_q, err_d;

  assign bad_wr = wr_vld_q && ((bus.src_data[3:0] > 4'd9) || (bus.src_data[7:4] > 4'd9));

  always_comb begin
    cap_bad_d = cap_bad_q;
    err_d     = err_q;
    if (state_q == IDLE && vbs_q) cap_bad_d = 1'b0;
    if (bad_wr) begin
      cap_bad_d = 1'b1;
      err_d     = 1'b1;
    end
    // A clean capture clears the flag when that capture completes.
    if (state_q == DONE && !cap_bad_q) err_d = 1'b0;
  end

  assign bcd_err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_bad_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cap_bad_q <= cap_bad_d;
      err_q     <= err_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vb_lvl_q   <= 1'b1;
      vbs_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_vld_q   <= 1'b0;
      wr_sel_q   <= '0;
      shadow_q   <= {NUM_CH{{2{ASC_0}}}};
      rd_ascii_q <= ASC_0;
      frm_q      <= '0;
      ph_q       <= 1'b0;
      hide_q     <= 1'b0;
    end else begin
      vb_lvl_q   <= vb_lvl_d;
      vbs_q      <= vbs_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_vld_q   <= wr_vld_d;
      wr_sel_q   <= wr_sel_d;
      shadow_q   <= shadow_d;
      rd_ascii_q <= rd_ascii_d;
      frm_q      <= frm_d;
      ph_q       <= ph_d;
      hide_q     <= hide_d;
    end
  end

endmodule

// File: tb/tb_vga_bcd_snapshot.sv
// ---------------------------------------------------------------------------
// tb_vga_bcd_snapshot
//   Directed bench for vga_bcd_snapshot. A frame-level reference model is
//   checked against the DUT on every cycle. Literal expectations are
//   computed by hand from the frame/digit rules.
// ---------------------------------------------------------------------------
module tb_vga_bcd_snapshot;
  localparam int NUM_CH   = 11;
  localparam int CH_W     = 4;
  localparam int V_ACTIVE = 480;
  localparam int BF       = 30;
  localparam int BAND_TOP = 473;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [9:0]      pixely = '0;
  logic [CH_W-1:0] cursor;
  logic            ring;
  logic            cursor_hide, alarm_band, snap_busy, snap_done;
`ifdef BCD_CHECK_EN
  logic            bcd_err;
`endif

  vga_bcd_snapshot_if #(.CH_W(CH_W)) bus ();

  vga_bcd_snapshot #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .V_ACTIVE(V_ACTIVE),
    .BLINK_FRAMES(BF), .BAND_TOP(BAND_TOP)
  ) dut (
    .clk(clk), .reset(reset), .pixely(pixely), .bus(bus),
    .cursor(cursor), .ring(ring),
    .cursor_hide(cursor_hide), .alarm_band(alarm_band),
    .snap_busy(snap_busy), .snap_done(snap_done)
`ifdef BCD_CHECK_EN
    , .bcd_err(bcd_err)
`endif
  );

  always #5 clk = ~clk;

  // RTC register bank: data follows src_sel by one cycle.
  logic [7:0] bank [16];
  always @(posedge clk) bus.src_data <= bank[bus.src_sel];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   cap = 0 while idle. Otherwise cap counts clock edges from the
  //   capture start: 1..NUM_CH+1 is busy and NUM_CH+2 is the done cycle.
  //   The whole bank snapshot becomes visible when the capture is done.
  // ---------------------------------------------------------------------------
  logic [6:0] m_sh [NUM_CH][2];
  int         cap, frm;
  bit         vb_prev, vbs_pend, m_ph, m_err, m_hide;
  logic [6:0] m_rd;

  function automatic logic [6:0] asc(input int n);
`ifdef BCD_CHECK_EN
    if (n > 9) return 7'h2D;
`endif
    return 7'(8'h30 + n);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_sh[c][0] = 7'h30;
        m_sh[c][1] = 7'h30;
      end
      cap = 0; frm = 0; m_ph = 0; m_err = 0;
      vb_prev = 1; vbs_pend = 0;
      m_rd = 7'h30; m_hide = 0;
    end else begin
      bit lvl;
      lvl = (pixely >= V_ACTIVE);
      if (int'(bus.rd_ch) < NUM_CH) m_rd = m_sh[bus.rd_ch][bus.rd_digit];
      else m_rd = 7'h20;
      m_hide = (bus.rd_ch == cursor) && (int'(cursor) < NUM_CH) && m_ph;
      if (cap >= 1) cap = (cap == NUM_CH + 2) ? 0 : cap + 1;
      else if (vbs_pend) cap = 1;
      if (cap == NUM_CH + 2) begin
        m_err = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          m_sh[c][0] = asc(int'(bank[c][3:0]));
          m_sh[c][1] = asc(int'(bank[c][7:4]));
          if (bank[c][3:0] > 9 || bank[c][7:4] > 9) m_err = 1;
        end
      end
      if (vbs_pend) begin
        if (frm == BF - 1) begin
          frm = 0;
          m_ph = !m_ph;
        end else begin
          frm++;
        end
      end
      vbs_pend = lvl && !vb_prev;
      vb_prev = lvl;
    end
  end

  // Per-cycle compare, half a cycle after the active edge.
  int done_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (snap_done) done_cnt++;
      chk("snap_busy", snap_busy, int'(cap >= 1 && cap <= NUM_CH + 1));
      chk("snap_done", snap_done, int'(cap == NUM_CH + 2));
      chk("cursor_hide", cursor_hide, m_hide);
      chk("alarm_band", alarm_band,
          int'(ring && m_ph && pixely >= BAND_TOP && pixely < V_ACTIVE));
      if (cap == 0) chk("rd_ascii", bus.rd_ascii, m_rd);
`ifdef BCD_CHECK_EN
      if (cap == 0) chk("bcd_err", bcd_err, m_err);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 2 time units after each rising edge.
  // ---------------------------------------------------------------------------
  task automatic rd_chk(input int ch, input int dig, input int exp, input string nm);
    @(posedge clk); #2;
    bus.rd_ch = CH_W'(ch);
    bus.rd_digit = dig[0];
    @(posedge clk);
    @(negedge clk);
    chk(nm, bus.rd_ascii, exp);
  endtask

  task automatic frame();
    @(posedge clk); #2 pixely = 10'd479;
    repeat (2) @(posedge clk);
    #2 pixely = 10'd480;
    repeat (17) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int lat, d0;
    bit hit;
    for (int i = 0; i < 16; i++) bank[i] = {4'(i % 10), 4'(9 - (i % 10))};
    bank[0] = 8'h59; bank[2] = 8'h23;
    bus.rd_ch = '0; bus.rd_digit = 1'b0;
    cursor = 4'hF; ring = 1'b0; pixely = 10'd0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("reset_rd_ascii", bus.rd_ascii, 7'h30);
    chk("reset_busy", snap_busy, 0);
    chk("reset_band", alarm_band, 0);
    chk("reset_src_sel", bus.src_sel, 0);

    // Capture latency measured from the edge that first samples pixely=480.
    @(posedge clk); #2 pixely = 10'd479;
    repeat (3) @(posedge clk);
    #2 pixely = 10'd480;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (snap_done) begin
        lat = k - 1;
        break;
      end
    end
    chk("capture_latency", lat, NUM_CH + 2);
    rd_chk(0, 0, 7'h39, "ch0_units");
    rd_chk(0, 1, 7'h35, "ch0_tens");
    rd_chk(2, 0, 7'h33, "ch2_units");
    rd_chk(2, 1, 7'h32, "ch2_tens");
    rd_chk(NUM_CH, 0, 7'h20, "ch_oob_space");

    // Sweep the whole blanking interval; only one capture may occur.
    @(posedge clk); #2 pixely = 10'd479;
    repeat (3) @(posedge clk);
    d0 = done_cnt;
    for (int y = 480; y <= 524; y++) begin
      #2 pixely = 10'(y);
      repeat (2) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("one_snap_per_blank", done_cnt - d0, 1);

    // Blink: the phase toggles after every 30 frames.
    do_reset();
    cursor = 4'd1; bus.rd_ch = 4'd1; bus.rd_digit = 1'b0;
    repeat (29) frame();
    @(negedge clk);
    chk("hide_frame29", cursor_hide, 0);
    frame();
    @(negedge clk);
    chk("hide_frame30", cursor_hide, 1);
    @(posedge clk); #2 bus.rd_ch = 4'd3;
    @(posedge clk); @(negedge clk);
    chk("hide_other_ch", cursor_hide, 0);

    // Alarm band during flash-on.
    @(posedge clk); #2 ring = 1'b1; pixely = 10'd475;
    @(negedge clk);
    chk("band_in", alarm_band, 1);
    @(posedge clk); #2 pixely = 10'd472;
    @(negedge clk);
    chk("band_above", alarm_band, 0);
    @(posedge clk); #2 pixely = 10'd479;
    @(negedge clk);
    chk("band_last_line", alarm_band, 1);
    @(posedge clk); #2 ring = 1'b0;
    @(negedge clk);
    chk("band_ring_fall", alarm_band, 0);

    @(posedge clk); #2 bus.rd_ch = 4'd1;
    repeat (29) frame();
    @(negedge clk);
    chk("hide_frame59", cursor_hide, 1);
    frame();
    @(negedge clk);
    chk("hide_frame60", cursor_hide, 0);

    // Reset in the middle of a fetch.
    @(posedge clk); #2 pixely = 10'd479;
    repeat (2) @(posedge clk);
    #2 pixely = 10'd480;
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.src_sel == 4'd5) begin
        hit = 1;
        break;
      end
    end
    chk("reach_src_sel5", int'(hit), 1);
    #1 reset = 1'b0;
    #1;
    chk("midreset_busy", snap_busy, 0);
    chk("midreset_src_sel", bus.src_sel, 0);
    chk("midreset_rd_ascii", bus.rd_ascii, 7'h30);
    chk("midreset_hide", cursor_hide, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_capture_after_reset", snap_busy, 0);
    rd_chk(0, 0, 7'h30, "post_reset_ch0_units");
    rd_chk(2, 1, 7'h30, "post_reset_ch2_tens");

    // Invalid BCD nibble.
    bank[4] = 8'hA3;
    frame();
    rd_chk(4, 0, 7'h33, "bad_units");
`ifdef BCD_CHECK_EN
    rd_chk(4, 1, 7'h2D, "bad_tens");
    chk("bcd_err_set", bcd_err, 1);
`else
    rd_chk(4, 1, 7'h3A, "bad_tens");
`endif
    bank[4] = 8'h45;
    frame();
    rd_chk(4, 1, 7'h34, "fixed_tens");
`ifdef BCD_CHECK_EN
    chk("bcd_err_clear", bcd_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_bcd_snapshot.md
Name: vga_bcd_snapshot

Overview:
- Parametrised successor to the VGA data-capture stage of the RTC display path.
- Once per frame, at the start of vertical blanking, it copies NUM_CH packed-BCD bytes from the RTC/timer register bank into a shadow bank, walking a muxed source port one channel per cycle.
- The text renderer reads the shadow bank as 7-bit ASCII digits with 1-cycle latency.
- The block also generates the per-frame cursor blink and the alarm-band flash.

Parameters:
- NUM_CH, 11, number of 8-bit BCD channels captured per frame.
- CH_W, 4, width of channel index; must satisfy 2^CH_W >= NUM_CH.
- V_ACTIVE, 480, first non-visible line; capture triggers when pixely reaches it.
- BLINK_FRAMES, 30, frames per half-period of cursor blink and alarm flash.
- BAND_TOP, 473, first line of the alarm band (band runs BAND_TOP..V_ACTIVE-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- pixely  input  10  current line from the VGA sync generator.
- src_sel  output  CH_W  channel index presented to the RTC register bank.
- src_data  input  8  packed BCD of channel src_sel, valid 1 cycle after src_sel changes.
- rd_ch  input  CH_W  renderer channel select.
- rd_digit  input  1  0 = units nibble, 1 = tens nibble.
- rd_ascii  output  7  registered ASCII of the selected digit.
- cursor  input  CH_W  channel under edit; value >= NUM_CH means no cursor.
- ring  input  1  alarm active.
- cursor_hide  output  1  high when rd_ch == cursor and blink phase is off (aligned with rd_ascii).
- alarm_band  output  1  high when ring, flash phase on, and pixely in band.
- snap_busy  output  1  capture in progress.
- snap_done  output  1  one-cycle pulse when capture completes.

Behaviour:
- Reset (reset low, asynchronous):
  - All shadow digits = 7'h30 ('0').
  - rd_ascii = 7'h30; src_sel, frame counter, blink phase = 0.
  - snap_busy, snap_done, cursor_hide, alarm_band = 0.
  - FSM returns to IDLE.
- Trigger: vblank_start is the registered rising edge of (pixely >= V_ACTIVE). It fires once per frame, not continuously during blanking.
- IDLE:
  - Hold src_sel = 0.
  - On vblank_start: go to FETCH, snap_busy = 1.
- FETCH (NUM_CH+1 cycles):
  - src_sel counts 0..NUM_CH-1, one per cycle.
  - Each cycle, src_data is written into shadow[src_sel delayed 1] as {3'b011, nibble} for units and tens.
  - After the last write, go to DONE.
- DONE (1 cycle): snap_done = 1, snap_busy = 0, go to IDLE.
- Total capture latency: vblank_start to snap_done = NUM_CH+2 cycles.
- vblank_start during FETCH/DONE: ignored; no restart or re-arm.
- Read path: rd_ascii <= shadow[rd_ch][rd_digit] every cycle.
  - rd_ch >= NUM_CH returns 7'h20 (space).
  - Reads during FETCH may return a mix of old and new values; the renderer reads only in the active area.
- Frame counter: increments on each vblank_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- cursor_hide: registered, so it is aligned with rd_ascii.
- alarm_band: combinational from the ring/phase/pixely terms; deasserts within 1 cycle of ring falling.
- Reset mid-FETCH: shadow keeps the reset values. The next capture happens at the next vblank_start.

Optional Feature:
- BCD_CHECK_EN defined:
  - Any nibble > 9 is stored as 7'h2D ('-') instead of {3'b011, nibble}.
  - Adds output bcd_err (1 bit), sticky. It sets on any invalid nibble during FETCH and clears on the next snap_done of a capture with no invalid nibbles.
- BCD_CHECK_EN undefined:
  - Nibbles are stored unchecked (e.g. 4'hA gives 7'h3A ':').
  - bcd_err is absent.

Test Plan:
- Reset release, rd_ch = 0, rd_digit = 0 -> rd_ascii = 7'h30; snap_busy = 0; alarm_band = 0.
- Source model returns 8'h59 for channel 0 and 8'h23 for channel 2; drive pixely 479 -> 480 -> snap_done exactly NUM_CH+2 cycles later. Then rd_ch = 0 gives units 7'h39 and tens 7'h35; rd_ch = 2 gives units 7'h33 and tens 7'h32.
- Hold pixely = 480..524 for 45 lines -> exactly one snap_done pulse.
- cursor = 1, rd_ch = 1, generate 60 frames -> cursor_hide toggles every 30 frames; with rd_ch = 3, cursor_hide stays 0.
- ring = 1, pixely = 475 during flash-on -> alarm_band = 1; pixely = 472 -> alarm_band = 0; ring falls -> alarm_band = 0 next cycle.
- Assert reset low during FETCH at src_sel = 5 -> all outputs reset immediately and shadow reads 7'h30. With BCD_CHECK_EN defined, a source value of 8'hA3 is read as a units digit of 7'h33, a tens digit of 7'h2D, and bcd_err = 1.
